// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning block: FSM state
// encoding, board default debounce length and the counter width helper.
package key_pkg;

   localparam logic [1:0] ST_RELEASED     = 2'd0;
   localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

   // 20 ms of stability at the 50 MHz board clock
   localparam int unsigned DEBOUNCE_CYCLES_50MHZ_20MS = 1_000_000;

   typedef enum logic [1:0] {
      RELEASED     = ST_RELEASED,
      PRESS_PEND   = ST_PRESS_PEND,
      PRESSED      = ST_PRESSED,
      RELEASE_PEND = ST_RELEASE_PEND
   } key_state_e;

   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: inverting two-flop synchronizer, debounce FSM with
// run-length counter, registered level and press/release strobes.
//
// state        | meaning
// RELEASED     | key accepted as released, counter idle
// PRESS_PEND   | synchronized key pressed, counting stable cycles
// PRESSED      | key accepted as pressed, counter idle
// RELEASE_PEND | synchronized key released, counting stable cycles
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_20MS,
   parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       sync_q;
   logic             s;
   key_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             press_q;
   logic             release_q;

   // Reset value 0 means "released", matching an idle active-low pin.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[0], ~key_raw_i};
      end
   end

   assign s = sync_q[1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            RELEASED: begin
               if (s) begin
                  state_q <= PRESS_PEND;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            PRESS_PEND: begin
               if (!s) begin
                  state_q <= RELEASED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            PRESSED: begin
               if (!s) begin
                  state_q <= RELEASE_PEND;
                  cnt_q   <= CNT_ONE;
               end else begin
                  cnt_q   <= '0;
               end
            end
            RELEASE_PEND: begin
               if (s) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= RELEASED;
                  cnt_q     <= '0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  cnt_q     <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= RELEASED;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Board push-button conditioner: N_KEYS independent debounce channels with
// active-high level and one-cycle press/release strobes.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_20MS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk_i     (clk),
         .rst_ni    (rst_n),
         .key_raw_i (key_raw[g]),
         .level_o   (key_level[g]),
         .press_o   (key_press[g]),
         .release_o (key_release[g])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model compared every cycle,
// directed latency/boundary scenarios, then randomized bouncing keys.
module tb_key_debounce;

   localparam int NK  = 4;
   localparam int DEB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NK-1:0] key_raw;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;

   int n_checks = 0;
   int n_pass   = 0;
   bit done     = 1'b0;

   key_debounce #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_raw),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: a pressed/released decision flips once the synchronized key
   // has disagreed with it for DEB consecutive samples (2-sample pipe delay).
   logic [NK-1:0] m_pipe1 = '0;
   logic [NK-1:0] m_pipe2 = '0;
   logic [NK-1:0] m_level = '0;
   logic [NK-1:0] m_press = '0;
   logic [NK-1:0] m_rel   = '0;
   int            m_run [NK];

   initial begin
      for (int k = 0; k < NK; k++) m_run[k] = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pipe1 = '0; m_pipe2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            for (int k = 0; k < NK; k++) m_run[k] = 0;
         end else begin
            for (int k = 0; k < NK; k++) begin
               logic sv;
               sv = m_pipe2[k];
               m_pipe2[k] = m_pipe1[k];
               m_pipe1[k] = ~key_raw[k];
               m_press[k] = 1'b0;
               m_rel[k]   = 1'b0;
               if (sv != m_level[k]) begin
                  m_run[k]++;
                  if (m_run[k] == DEB) begin
                     m_level[k] = sv;
                     m_run[k]   = 0;
                     if (sv) m_press[k] = 1'b1;
                     else    m_rel[k]   = 1'b1;
                  end
               end else begin
                  m_run[k] = 0;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!done) begin
            chk("model_level",   32'(key_level),   32'(m_level));
            chk("model_press",   32'(key_press),   32'(m_press));
            chk("model_release", 32'(key_release), 32'(m_rel));
         end
      end
   end

   // Edges from the first sampling edge until any masked strobe bit shows.
   task automatic count_edges(input logic [NK-1:0] mask, input bit rel,
                              output int edges, output logic [NK-1:0] val);
      edges = -1;
      val   = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         val = rel ? key_release : key_press;
         if ((val & mask) != '0) begin
            edges = i;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int ncyc, input int key, output int np, output int nr);
      np = 0;
      nr = 0;
      repeat (ncyc) begin
         @(posedge clk); #1;
         if (key_press[key])   np++;
         if (key_release[key]) nr++;
      end
   endtask

   task automatic settle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish, %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      int            e, np, nr, np2, nr2;
      logic [NK-1:0] v;
      int            hold [NK];

      // Reset with all keys held, then fresh presses 10 edges after release
      key_raw = '0;
      rst_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_level",   32'(key_level),   32'h0);
      chk("rst_press",   32'(key_press),   32'h0);
      chk("rst_release", 32'(key_release), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      count_edges(4'hF, 1'b0, e, v);
      chk("rst_press_edges", 32'(e), 32'd10);
      chk("rst_press_val",   32'(v), 32'hF);
      chk("rst_level_after", 32'(key_level), 32'hF);
      settle(1);
      chk("rst_press_1cyc",  32'(key_press), 32'h0);

      // Clean press on key 0
      key_raw = 4'hF;
      settle(20);
      key_raw[0] = 1'b0;
      count_edges(4'h1, 1'b0, e, v);
      chk("clean_edges", 32'(e), 32'd10);
      chk("clean_level", 32'(key_level[0]), 32'h1);
      count_pulses(100, 0, np, nr);
      chk("clean_no_repeat", 32'(np), 32'd0);

      // Bounce on key 1, then settle pressed
      np2 = 0; nr2 = 0;
      for (int i = 0; i < 40; i++) begin
         key_raw[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
         @(posedge clk); #1;
         if (key_press[1])   np2++;
         if (key_release[1]) nr2++;
      end
      chk("bounce_press_during", 32'(np2), 32'd0);
      chk("bounce_rel_during",   32'(nr2), 32'd0);
      key_raw[1] = 1'b0;
      count_edges(4'h2, 1'b0, e, v);
      chk("bounce_settle_edges", 32'(e), 32'd10);
      count_pulses(30, 1, np, nr);
      chk("bounce_extra_press", 32'(np), 32'd0);
      chk("bounce_release",     32'(nr), 32'd0);

      // Boundary on key 2: 7 samples rejected, 8 accepted
      key_raw[2] = 1'b0;
      count_pulses(7, 2, np, nr);
      key_raw[2] = 1'b1;
      count_pulses(20, 2, np2, nr2);
      chk("bound7_press", 32'(np + np2), 32'd0);
      key_raw[2] = 1'b0;
      count_pulses(8, 2, np, nr);
      key_raw[2] = 1'b1;
      count_pulses(20, 2, np2, nr2);
      chk("bound8_press", 32'(np + np2), 32'd1);

      // Simultaneous release of keys 3 and 0
      key_raw[3] = 1'b0;
      settle(20);
      key_raw[3] = 1'b1;
      key_raw[0] = 1'b1;
      count_edges(4'h9, 1'b1, e, v);
      chk("simul_edges", 32'(e), 32'd10);
      chk("simul_val",   32'(v), 32'h9);

      // Reset while key 0 is mid-debounce (cnt 5), key 3 already pressed
      key_raw = 4'hF;
      settle(20);
      key_raw[3] = 1'b0;
      settle(20);
      key_raw[0] = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_level",   32'(key_level),   32'h0);
      chk("midrst_press",   32'(key_press),   32'h0);
      chk("midrst_release", 32'(key_release), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      count_edges(4'hF, 1'b0, e, v);
      chk("midrst_edges", 32'(e), 32'd10);
      chk("midrst_val",   32'(v), 32'h9);

      // Randomized bouncing on all keys, with one asynchronous reset pulse
      for (int k = 0; k < NK; k++) hold[k] = 0;
      for (int i = 0; i < 4000; i++) begin
         for (int k = 0; k < NK; k++) begin
            if (hold[k] == 0) begin
               int r;
               key_raw[k] = ~key_raw[k];
               r = int'($urandom_range(0, 9));
               if (r < 5)       hold[k] = int'($urandom_range(1, 6));
               else if (r == 5) hold[k] = DEB - 1;
               else if (r == 6) hold[k] = DEB;
               else             hold[k] = int'($urandom_range(9, 30));
            end else begin
               hold[k]--;
            end
         end
         if (i == 2000) begin
            #3 rst_n = 1'b0;
            #4 rst_n = 1'b1;
         end
         @(posedge clk); #1;
      end

      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
